// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues one-shot data-memory requests, holds EX/MEM until completion,
// and registers the writeback bundle with bubbles, misalignment/timeout errors and halt handling.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid_In,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic [2:0]  WriteReg,
    input  logic        Halt,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_Rd,
    output logic        mem_Wr,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_Stall,
    output logic        Stall_Out,
    output logic        Valid_Out,
    output logic [15:0] WBData,
    output logic        RegWrite_Out,
    output logic [2:0]  WriteReg_Out,
    output logic        Halt_Out,
    output logic        Err_Out
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cntInc;
    logic          valid_q, valid_d;
    logic [15:0]   wbData_q, wbData_d;
    logic          regWrite_q, regWrite_d;
    logic [2:0]    writeReg_q, writeReg_d;
    logic          halt_q, halt_d;
    logic          err_q, err_d;
    logic          stall, rdStrobe, wrStrobe, issue, memOp;

    assign memOp  = MemRead | MemWrite;
    assign cntInc = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        wbData_d   = wbData_q;
        regWrite_d = 1'b0;
        writeReg_d = writeReg_q;
        halt_d     = halt_q;
        err_d      = err_q;
        stall      = 1'b0;
        rdStrobe   = 1'b0;
        wrStrobe   = 1'b0;
        issue      = 1'b0;

        case (state_q)
            IDLE: begin
                if (Valid_In) begin
                    if (memOp) begin
                        stall = 1'b1;
                        if (Address[0]) begin
                            err_d   = 1'b1;
                            halt_d  = 1'b1;
                            state_d = STOP;
                        end else if (!mem_Stall) begin
                            // A combined read+write request is treated as a store.
                            issue    = 1'b1;
                            wrStrobe = MemWrite;
                            rdStrobe = MemRead & ~MemWrite;
                            cnt_d    = '0;
                            state_d  = WAIT;
                        end
                    end else if (Halt) begin
                        halt_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        valid_d    = 1'b1;
                        wbData_d   = Address;
                        regWrite_d = RegWrite;
                        writeReg_d = WriteReg;
                    end
                end
            end
            WAIT: begin
                if (mem_Done) begin
                    valid_d    = 1'b1;
                    wbData_d   = MemToReg ? mem_DataOut : Address;
                    regWrite_d = RegWrite;
                    writeReg_d = WriteReg;
                    if (Halt) begin
                        halt_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stall = 1'b1;
                    cnt_d = cntInc;
                    if (cntInc == CW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        halt_d  = 1'b1;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            wbData_q   <= '0;
            regWrite_q <= 1'b0;
            writeReg_q <= '0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            wbData_q   <= wbData_d;
            regWrite_q <= regWrite_d;
            writeReg_q <= writeReg_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
        end
    end

    // Combinational outputs are forced low while reset is held so no request escapes.
    assign Stall_Out    = rst & stall;
    assign mem_Rd       = rst & rdStrobe;
    assign mem_Wr       = rst & wrStrobe;
    assign mem_Addr     = (rst & issue) ? Address   : 16'h0000;
    assign mem_DataIn   = (rst & issue) ? WriteData : 16'h0000;

    assign Valid_Out    = valid_q;
    assign WBData       = wbData_q;
    assign RegWrite_Out = valid_q & regWrite_q;
    assign WriteReg_Out = writeReg_q;
    assign Halt_Out     = halt_q;
    assign Err_Out      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a cycle-by-cycle vector table followed by hand-written
// sequences for misalignment, timeout, done-on-the-deadline and reset during an access.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid_In, MemRead, MemWrite, MemToReg, RegWrite, Halt;
    logic [15:0] Address, WriteData, mem_DataOut;
    logic [2:0]  WriteReg;
    logic        mem_Done, mem_Stall;
    logic [15:0] mem_Addr, mem_DataIn, WBData;
    logic        mem_Rd, mem_Wr, Stall_Out, Valid_Out, RegWrite_Out, Halt_Out, Err_Out;
    logic [2:0]  WriteReg_Out;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .Valid_In(Valid_In), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .Halt(Halt),
        .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
        .Stall_Out(Stall_Out), .Valid_Out(Valid_Out), .WBData(WBData),
        .RegWrite_Out(RegWrite_Out), .WriteReg_Out(WriteReg_Out),
        .Halt_Out(Halt_Out), .Err_Out(Err_Out)
    );

    typedef struct {
        logic        v;
        logic [15:0] addr, wdata;
        logic        rd, wr, m2r, rw;
        logic [2:0]  wreg;
        logic        halt, mstall, done;
        logic [15:0] dout;
        logic        eStall, eRd, eWr;
        logic [15:0] eAddr, eDin;
        logic        eValid;
        logic [15:0] eWb;
        logic        eRw;
        logic [2:0]  eWreg;
        logic        eHalt, eErr;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        input logic v, input logic [15:0] addr, input logic [15:0] wdata,
        input logic rd, input logic wr, input logic m2r, input logic rw, input logic [2:0] wreg,
        input logic halt, input logic mstall, input logic done, input logic [15:0] dout,
        input logic eStall, input logic eRd, input logic eWr, input logic [15:0] eAddr,
        input logic [15:0] eDin, input logic eValid, input logic [15:0] eWb, input logic eRw,
        input logic [2:0] eWreg, input logic eHalt, input logic eErr);
        vec_t r;
        r.v = v; r.addr = addr; r.wdata = wdata; r.rd = rd; r.wr = wr; r.m2r = m2r;
        r.rw = rw; r.wreg = wreg; r.halt = halt; r.mstall = mstall; r.done = done;
        r.dout = dout; r.eStall = eStall; r.eRd = eRd; r.eWr = eWr; r.eAddr = eAddr;
        r.eDin = eDin; r.eValid = eValid; r.eWb = eWb; r.eRw = eRw; r.eWreg = eWreg;
        r.eHalt = eHalt; r.eErr = eErr;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clearInputs();
        Valid_In = 0; Address = 0; WriteData = 0; MemRead = 0; MemWrite = 0; MemToReg = 0;
        RegWrite = 0; WriteReg = 0; Halt = 0; mem_Stall = 0; mem_Done = 0; mem_DataOut = 0;
    endtask

    task automatic applyStimulus(input vec_t t);
        Valid_In = t.v; Address = t.addr; WriteData = t.wdata; MemRead = t.rd; MemWrite = t.wr;
        MemToReg = t.m2r; RegWrite = t.rw; WriteReg = t.wreg; Halt = t.halt;
        mem_Stall = t.mstall; mem_Done = t.done; mem_DataOut = t.dout;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 0;
        clearInputs();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic driveLoad(input logic [15:0] addr, input logic [2:0] wreg);
        clearInputs();
        Valid_In = 1; Address = addr; MemRead = 1; MemToReg = 1; RegWrite = 1; WriteReg = wreg;
    endtask

    initial begin
        vecs[0]  = mk(1,16'h1234,0,0,0,0,1,5,0,0,0,0,          0,0,0,0,0,                1,16'h1234,1,5,0,0);
        vecs[1]  = mk(0,16'hFFFF,0,0,0,0,1,6,0,0,0,0,          0,0,0,0,0,                0,0,0,0,0,0);
        vecs[2]  = mk(1,16'h00AA,0,0,0,0,0,2,0,0,0,0,          0,0,0,0,0,                1,16'h00AA,0,2,0,0);
        vecs[3]  = mk(1,16'h0040,0,1,0,1,1,3,0,0,0,0,          1,1,0,16'h0040,0,         0,0,0,0,0,0);
        vecs[4]  = mk(1,16'h0040,0,1,0,1,1,3,0,0,0,0,          1,0,0,0,0,                0,0,0,0,0,0);
        vecs[5]  = mk(1,16'h0040,0,1,0,1,1,3,0,0,0,0,          1,0,0,0,0,                0,0,0,0,0,0);
        vecs[6]  = mk(1,16'h0040,0,1,0,1,1,3,0,0,1,16'hBEEF,   0,0,0,0,0,                1,16'hBEEF,1,3,0,0);
        vecs[7]  = mk(0,0,0,0,0,0,0,0,0,0,1,16'hDEAD,          0,0,0,0,0,                0,0,0,0,0,0);
        vecs[8]  = mk(1,16'h0100,16'hCAFE,0,1,0,0,1,0,1,0,0,   1,0,0,0,0,                0,0,0,0,0,0);
        vecs[9]  = mk(1,16'h0100,16'hCAFE,0,1,0,0,1,0,1,0,0,   1,0,0,0,0,                0,0,0,0,0,0);
        vecs[10] = mk(1,16'h0100,16'hCAFE,0,1,0,0,1,0,0,0,0,   1,0,1,16'h0100,16'hCAFE,  0,0,0,0,0,0);
        vecs[11] = mk(1,16'h0100,16'hCAFE,0,1,0,0,1,0,0,0,0,   1,0,0,0,0,                0,0,0,0,0,0);
        vecs[12] = mk(1,16'h0100,16'hCAFE,0,1,0,0,1,0,0,1,16'h9999, 0,0,0,0,0,           1,16'h0100,0,1,0,0);
        vecs[13] = mk(1,16'h0200,16'h1357,1,1,1,1,7,0,0,0,0,   1,0,1,16'h0200,16'h1357,  0,0,0,0,0,0);
        vecs[14] = mk(1,16'h0200,16'h1357,1,1,1,1,7,0,0,1,16'h1111, 0,0,0,0,0,           1,16'h1111,1,7,0,0);
        vecs[15] = mk(1,16'h5555,0,0,0,0,1,4,1,0,0,0,          0,0,0,0,0,                0,0,0,0,1,0);
        vecs[16] = mk(1,16'h0040,0,1,0,1,1,3,0,0,0,0,          1,0,0,0,0,                0,0,0,0,1,0);

        rst = 0;
        clearInputs();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset Valid_Out", 16'(Valid_Out), 16'h0);
        checkOutput("reset WBData", WBData, 16'h0);
        checkOutput("reset RegWrite_Out", 16'(RegWrite_Out), 16'h0);
        checkOutput("reset WriteReg_Out", 16'(WriteReg_Out), 16'h0);
        checkOutput("reset Halt_Out", 16'(Halt_Out), 16'h0);
        checkOutput("reset Err_Out", 16'(Err_Out), 16'h0);
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d Stall_Out", i), 16'(Stall_Out), 16'(vecs[i].eStall));
            checkOutput($sformatf("v%0d mem_Rd", i), 16'(mem_Rd), 16'(vecs[i].eRd));
            checkOutput($sformatf("v%0d mem_Wr", i), 16'(mem_Wr), 16'(vecs[i].eWr));
            checkOutput($sformatf("v%0d mem_Addr", i), mem_Addr, vecs[i].eAddr);
            checkOutput($sformatf("v%0d mem_DataIn", i), mem_DataIn, vecs[i].eDin);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d Valid_Out", i), 16'(Valid_Out), 16'(vecs[i].eValid));
            checkOutput($sformatf("v%0d RegWrite_Out", i), 16'(RegWrite_Out), 16'(vecs[i].eRw));
            checkOutput($sformatf("v%0d Halt_Out", i), 16'(Halt_Out), 16'(vecs[i].eHalt));
            checkOutput($sformatf("v%0d Err_Out", i), 16'(Err_Out), 16'(vecs[i].eErr));
            if (vecs[i].eValid) begin
                checkOutput($sformatf("v%0d WBData", i), WBData, vecs[i].eWb);
                checkOutput($sformatf("v%0d WriteReg_Out", i), 16'(WriteReg_Out), 16'(vecs[i].eWreg));
            end
        end

        // Misaligned load
        doReset();
        @(negedge clk);
        driveLoad(16'h0041, 3'd2);
        #1;
        checkOutput("misalign mem_Rd", 16'(mem_Rd), 16'h0);
        checkOutput("misalign Stall_Out", 16'(Stall_Out), 16'h1);
        @(posedge clk);
        #1;
        checkOutput("misalign Err_Out", 16'(Err_Out), 16'h1);
        checkOutput("misalign Halt_Out", 16'(Halt_Out), 16'h1);
        checkOutput("misalign Valid_Out", 16'(Valid_Out), 16'h0);
        @(negedge clk);
        #1;
        checkOutput("misalign stop Stall_Out", 16'(Stall_Out), 16'h1);
        checkOutput("misalign stop mem_Rd", 16'(mem_Rd), 16'h0);

        // Load that never completes
        doReset();
        @(negedge clk);
        driveLoad(16'h0080, 3'd1);
        #1;
        checkOutput("timeout issue mem_Rd", 16'(mem_Rd), 16'h1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("timeout wait%0d mem_Rd", k), 16'(mem_Rd), 16'h0);
            checkOutput($sformatf("timeout wait%0d Stall_Out", k), 16'(Stall_Out), 16'h1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("timeout wait%0d Err_Out", k), 16'(Err_Out), (k == 8) ? 16'h1 : 16'h0);
        end
        @(negedge clk);
        #1;
        checkOutput("timeout Halt_Out", 16'(Halt_Out), 16'h1);
        checkOutput("timeout stop Stall_Out", 16'(Stall_Out), 16'h1);
        rst = 0;
        #1;
        checkOutput("async reset Err_Out", 16'(Err_Out), 16'h0);
        checkOutput("async reset Halt_Out", 16'(Halt_Out), 16'h0);
        checkOutput("async reset Stall_Out", 16'(Stall_Out), 16'h0);
        checkOutput("async reset mem_Rd", 16'(mem_Rd), 16'h0);
        clearInputs();
        @(negedge clk);
        rst = 1;

        // Done arrives on the last permitted WAIT cycle
        doReset();
        @(negedge clk);
        driveLoad(16'h0090, 3'd6);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            mem_Done = (k == 8);
            mem_DataOut = 16'hA5A4;
            @(posedge clk);
            #1;
        end
        checkOutput("deadline Err_Out", 16'(Err_Out), 16'h0);
        checkOutput("deadline Valid_Out", 16'(Valid_Out), 16'h1);
        checkOutput("deadline WBData", WBData, 16'hA5A4);
        checkOutput("deadline WriteReg_Out", 16'(WriteReg_Out), 16'h6);

        // Reset asserted while an access is outstanding
        doReset();
        @(negedge clk);
        driveLoad(16'h0060, 3'd4);
        @(negedge clk);
        rst = 0;
        #1;
        checkOutput("midwait reset Stall_Out", 16'(Stall_Out), 16'h0);
        checkOutput("midwait reset mem_Rd", 16'(mem_Rd), 16'h0);
        checkOutput("midwait reset Valid_Out", 16'(Valid_Out), 16'h0);
        clearInputs();
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_Done = (k == 1);
            #1;
            checkOutput($sformatf("post-reset%0d mem_Rd", k), 16'(mem_Rd), 16'h0);
            checkOutput($sformatf("post-reset%0d mem_Wr", k), 16'(mem_Wr), 16'h0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("post-reset%0d Valid_Out", k), 16'(Valid_Out), 16'h0);
        end
        @(negedge clk);
        driveLoad(16'h0062, 3'd4);
        #1;
        checkOutput("post-reset issue mem_Rd", 16'(mem_Rd), 16'h1);
        checkOutput("post-reset issue mem_Addr", mem_Addr, 16'h0062);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
